// File: rtl/arbitro_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_ram_pkg
// Brief   : Shared types and constants for the two-requester RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package arbitro_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DEF_DEPTH = 11;
    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 8;

endpackage
`default_nettype wire

// File: rtl/rr_arbitro2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbitro2
// Brief   : Two-input round-robin arbiter with one-hot grant and pointer flop.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbitro2
    import arbitro_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic       r_ptr_q;
    logic       w_ptr_d;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = i_req;
        if (i_req == 2'b11) begin
            w_gnt = (r_ptr_q == REQ_B) ? 2'b10 : 2'b01;
        end
        // Priority moves to the side that did not win, even if it was idle.
        w_ptr_d = r_ptr_q;
        if (i_en && (|i_req)) begin
            w_ptr_d = w_gnt[REQ_A] ? REQ_B : REQ_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= REQ_A;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/arbitro_ram.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_ram
// Brief   : Round-robin arbiter/sequencer for an asynchronous RAM, two ports.
// Revision: 1.0 - initial release
// ============================================================================
module arbitro_ram
    import arbitro_ram_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] dir_a,
    input  logic [AW-1:0] dir_b,
    input  logic [DW-1:0] dato_e_a,
    input  logic [DW-1:0] dato_e_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          err_a,
    output logic          err_b,
    output logic [DW-1:0] dato_s_a,
    output logic [DW-1:0] dato_s_b,
    output logic [AW-1:0] ram_dir,
    output logic [DW-1:0] ram_dato_e,
    output logic          ram_en,
    input  logic [DW-1:0] ram_dato_s,
    output logic          busy
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    state_t        r_state_q, w_state_d;
    logic          r_win_q, w_win_d;
    logic          r_we_q, w_we_d;
    logic          r_err_q, w_err_d;
    logic          r_ack_a_q, w_ack_a_d;
    logic          r_ack_b_q, w_ack_b_d;
    logic          r_err_a_q, w_err_a_d;
    logic          r_err_b_q, w_err_b_d;
    logic [DW-1:0] r_dato_s_a_q, w_dato_s_a_d;
    logic [DW-1:0] r_dato_s_b_q, w_dato_s_b_d;
    logic [AW-1:0] r_ram_dir_q, w_ram_dir_d;
    logic [DW-1:0] r_ram_dato_e_q, w_ram_dato_e_d;
    logic          r_ram_en_q, w_ram_en_d;
    logic          r_busy_q, w_busy_d;

    logic [1:0]    w_gnt;
    logic          w_win;
    logic          w_we;
    logic [AW-1:0] w_dir;
    logic [DW-1:0] w_dat;
    logic          w_oor;

    rr_arbitro2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req ({req_b, req_a}),
        .i_en  (r_state_q == IDLE),
        .o_gnt (w_gnt)
    );

    assign w_win = w_gnt[REQ_B] ? REQ_B : REQ_A;
    assign w_we  = (w_win == REQ_B) ? we_b     : we_a;
    assign w_dir = (w_win == REQ_B) ? dir_b    : dir_a;
    assign w_dat = (w_win == REQ_B) ? dato_e_b : dato_e_a;
    assign w_oor = ({1'b0, w_dir} >= c_DEPTH);

    always_comb begin
        w_state_d      = r_state_q;
        w_win_d        = r_win_q;
        w_we_d         = r_we_q;
        w_err_d        = r_err_q;
        w_ack_a_d      = 1'b0;
        w_ack_b_d      = 1'b0;
        w_err_a_d      = 1'b0;
        w_err_b_d      = 1'b0;
        w_dato_s_a_d   = r_dato_s_a_q;
        w_dato_s_b_d   = r_dato_s_b_q;
        w_ram_dir_d    = r_ram_dir_q;
        w_ram_dato_e_d = r_ram_dato_e_q;
        w_ram_en_d     = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (|w_gnt) begin
                    // RAM pins are loaded here so they are flop-driven and
                    // stable across the whole ACCESS cycle.
                    w_win_d        = w_win;
                    w_we_d         = w_we;
                    w_err_d        = w_oor;
                    w_ram_dir_d    = w_dir;
                    w_ram_dato_e_d = w_dat;
                    w_ram_en_d     = w_we & ~w_oor;
                    w_state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (!r_we_q && !r_err_q) begin
                    if (r_win_q == REQ_B) w_dato_s_b_d = ram_dato_s;
                    else                  w_dato_s_a_d = ram_dato_s;
                end
                if (r_win_q == REQ_B) begin
                    w_ack_b_d = 1'b1;
                    w_err_b_d = r_err_q;
                end else begin
                    w_ack_a_d = 1'b1;
                    w_err_a_d = r_err_q;
                end
                w_state_d = DONE;
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_win_q        <= REQ_A;
            r_we_q         <= 1'b0;
            r_err_q        <= 1'b0;
            r_ack_a_q      <= 1'b0;
            r_ack_b_q      <= 1'b0;
            r_err_a_q      <= 1'b0;
            r_err_b_q      <= 1'b0;
            r_dato_s_a_q   <= '0;
            r_dato_s_b_q   <= '0;
            r_ram_dir_q    <= '0;
            r_ram_dato_e_q <= '0;
            r_ram_en_q     <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_win_q        <= w_win_d;
            r_we_q         <= w_we_d;
            r_err_q        <= w_err_d;
            r_ack_a_q      <= w_ack_a_d;
            r_ack_b_q      <= w_ack_b_d;
            r_err_a_q      <= w_err_a_d;
            r_err_b_q      <= w_err_b_d;
            r_dato_s_a_q   <= w_dato_s_a_d;
            r_dato_s_b_q   <= w_dato_s_b_d;
            r_ram_dir_q    <= w_ram_dir_d;
            r_ram_dato_e_q <= w_ram_dato_e_d;
            r_ram_en_q     <= w_ram_en_d;
            r_busy_q       <= w_busy_d;
        end
    end

    assign ack_a      = r_ack_a_q;
    assign ack_b      = r_ack_b_q;
    assign err_a      = r_err_a_q;
    assign err_b      = r_err_b_q;
    assign dato_s_a   = r_dato_s_a_q;
    assign dato_s_b   = r_dato_s_b_q;
    assign ram_dir    = r_ram_dir_q;
    assign ram_dato_e = r_ram_dato_e_q;
    assign ram_en     = r_ram_en_q;
    assign busy       = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_arbitro_ram
// Brief   : Scoreboard bench for arbitro_ram with a behavioural async RAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arbitro_ram;

    localparam int DEPTH = 11;
    localparam int AW    = 8;
    localparam int DW    = 8;

    logic          clk, rst;
    logic          req_a, req_b, we_a, we_b;
    logic [AW-1:0] dir_a, dir_b;
    logic [DW-1:0] dato_e_a, dato_e_b;
    logic          ack_a, ack_b, err_a, err_b;
    logic [DW-1:0] dato_s_a, dato_s_b;
    logic [AW-1:0] ram_dir;
    logic [DW-1:0] ram_dato_e;
    logic          ram_en;
    logic [DW-1:0] ram_dato_s;
    logic          busy;

    arbitro_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_b      (req_b),
        .we_a       (we_a),
        .we_b       (we_b),
        .dir_a      (dir_a),
        .dir_b      (dir_b),
        .dato_e_a   (dato_e_a),
        .dato_e_b   (dato_e_b),
        .ack_a      (ack_a),
        .ack_b      (ack_b),
        .err_a      (err_a),
        .err_b      (err_b),
        .dato_s_a   (dato_s_a),
        .dato_s_b   (dato_s_b),
        .ram_dir    (ram_dir),
        .ram_dato_e (ram_dato_e),
        .ram_en     (ram_en),
        .ram_dato_s (ram_dato_s),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous RAM model: combinational read, write while enabled.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_en && (int'(ram_dir) < DEPTH)) mem[ram_dir] <= ram_dato_e;
    end
    assign ram_dato_s = (int'(ram_dir) < DEPTH) ? mem[ram_dir] : 8'h00;

    typedef struct {
        logic          side;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack_a || ack_b) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {62'd0, ack_b, ack_a}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_side", {62'd0, ack_b, ack_a}, e.side ? 64'd2 : 64'd1);
                check("ack_err", e.side ? err_b : err_a, e.err);
                check("ack_data", e.side ? dato_s_b : dato_s_a, e.data);
            end
        end
    end

    int            en_cycles;
    logic [AW-1:0] en_dir;
    logic [DW-1:0] en_dat;
    always @(negedge clk) begin
        if (ram_en) begin
            en_cycles = en_cycles + 1;
            en_dir    = ram_dir;
            en_dat    = ram_dato_e;
        end
    end

    task automatic push_exp(input logic side, input logic err, input logic [DW-1:0] data);
        exp_t e;
        e.side = side;
        e.err  = err;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input logic side, input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(side ? ack_b : ack_a) && cyc < limit);
        if (!(side ? ack_b : ack_a)) check("ack_timeout", side ? ack_b : ack_a, 1);
    endtask

    task automatic txn(input logic side, input logic we, input logic [AW-1:0] dir,
                       input logic [DW-1:0] dat, input logic exp_err, input logic [DW-1:0] exp_data);
        int cyc;
        push_exp(side, exp_err, exp_data);
        @(posedge clk); #1;
        if (side) begin req_b = 1; we_b = we; dir_b = dir; dato_e_b = dat; end
        else      begin req_a = 1; we_a = we; dir_a = dir; dato_e_a = dat; end
        wait_ack(side, 10, cyc);
        check("latency", cyc, 3);
        @(posedge clk); #1;
        if (side) req_b = 0; else req_a = 0;
    endtask

    task automatic contend(input logic [AW-1:0] da, input logic [AW-1:0] db,
                           input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
        int cyc;
        push_exp(1'b0, 1'b0, exp_a);
        push_exp(1'b1, 1'b0, exp_b);
        @(posedge clk); #1;
        req_a = 1; we_a = 0; dir_a = da;
        req_b = 1; we_b = 0; dir_b = db;
        wait_ack(1'b0, 10, cyc);
        check("contend_a_first", cyc, 3);
        check("contend_b_not_yet", ack_b, 0);
        @(posedge clk); #1;
        req_a = 0;
        wait_ack(1'b1, 10, cyc);
        check("contend_b_gap", cyc, 3);
        @(posedge clk); #1;
        req_b = 0;
    endtask

    initial begin
        int ack_pos[3];
        int nack;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);
        rst = 1; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        dir_a = 0; dir_b = 0; dato_e_a = 0; dato_e_b = 0;
        en_cycles = 0; en_dir = 0; en_dat = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {ack_a, ack_b, err_a, err_b, ram_en, busy,
                                dato_s_a, dato_s_b, ram_dir, ram_dato_e}, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_reset_busy", busy, 0);

        // Pointer starts at A after reset.
        contend(8'd0, 8'd1, 8'hA0, 8'hA1);

        en_cycles = 0;
        txn(1'b0, 1'b1, 8'd3, 8'd55, 1'b0, 8'hA0);
        check("write_en_cycles", en_cycles, 1);
        check("write_en_dir", en_dir, 3);
        check("write_en_data", en_dat, 55);

        en_cycles = 0;
        txn(1'b0, 1'b0, 8'd3, 8'd0, 1'b0, 8'd55);
        check("read_en_cycles", en_cycles, 0);

        en_cycles = 0;
        txn(1'b1, 1'b1, 8'd11, 8'hFF, 1'b1, 8'hA1);
        check("oor_en_cycles", en_cycles, 0);
        check("oor_mem3", mem[3], 55);
        check("oor_mem10", mem[10], 8'hAA);

        // Pointer flipped to A by the error grant.
        contend(8'd2, 8'd3, 8'hA2, 8'd55);

        // Held request: three back-to-back reads of address 4.
        for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 8'hA4);
        nack = 0;
        @(posedge clk); #1;
        req_a = 1; we_a = 0; dir_a = 8'd4;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ack_a) begin
                if (nack < 3) ack_pos[nack] = k;
                nack++;
            end
        end
        @(posedge clk); #1;
        req_a = 0;
        for (int k = 10; k <= 12; k++) begin
            @(negedge clk);
            if (ack_a) nack++;
        end
        check("held_ack_count", nack, 3);
        check("held_ack_pos0", ack_pos[0], 3);
        check("held_ack_pos1", ack_pos[1], 6);
        check("held_ack_pos2", ack_pos[2], 9);

        // Reset while a B write is in ACCESS.
        @(posedge clk); #1;
        req_b = 1; we_b = 1; dir_b = 8'd4; dato_e_b = 8'h77;
        @(posedge clk); #1;
        rst = 1; req_b = 0;
        @(negedge clk);
        check("midrst_en_in_access", ram_en, 1);
        @(negedge clk);
        check("midrst_en", ram_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ack_b", ack_b, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (4) @(negedge clk);
        check("midrst_idle", busy, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
